// File: rtl/axis_client_arbiter_pkg.sv
// rtl/axis_client_arbiter_pkg.sv - shared AXIS widths, FSM state type and clog2 helper
package axis_client_arbiter_pkg;

  localparam int AXIS_MAX_DATAW = 32;
  localparam int AXIS_DESTW     = 4;
  localparam int AXIS_USERW     = 8;
  localparam int AXIS_IDW       = 4;
  localparam int AXIS_STRBW     = AXIS_MAX_DATAW / 8;
  localparam int AXIS_KEEPW     = AXIS_MAX_DATAW / 8;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } arb_state_t;

  // Index width for n items, never below one bit so single-client builds still have a port.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/axis_client_arbiter_if.sv
// rtl/axis_client_arbiter_if.sv - client request bundle plus NoC injection stream
interface axis_client_arbiter_if
  import axis_client_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int DATAW       = AXIS_MAX_DATAW,
  parameter int DESTW       = AXIS_DESTW,
  parameter int USERW       = AXIS_USERW,
  parameter int IDW         = AXIS_IDW
) ();

  logic [NUM_CLIENTS-1:0]       req_tvalid;
  logic [NUM_CLIENTS-1:0]       req_tlast;
  logic [NUM_CLIENTS*DATAW-1:0] req_tdata;
  logic [NUM_CLIENTS*DESTW-1:0] req_tdest;
  logic [NUM_CLIENTS*USERW-1:0] req_tuser;
  logic [NUM_CLIENTS-1:0]       req_tready;

  logic                  axis_tready;
  logic                  axis_tvalid;
  logic                  axis_tlast;
  logic [DATAW-1:0]      axis_tdata;
  logic [DESTW-1:0]      axis_tdest;
  logic [USERW-1:0]      axis_tuser;
  logic [IDW-1:0]        axis_tid;
  logic [AXIS_STRBW-1:0] axis_tstrb;
  logic [AXIS_KEEPW-1:0] axis_tkeep;

  modport master (
    output req_tvalid, req_tlast, req_tdata, req_tdest, req_tuser, axis_tready,
    input  req_tready, axis_tvalid, axis_tlast, axis_tdata, axis_tdest, axis_tuser,
    input  axis_tid, axis_tstrb, axis_tkeep
  );

  modport slave (
    input  req_tvalid, req_tlast, req_tdata, req_tdest, req_tuser, axis_tready,
    output req_tready, axis_tvalid, axis_tlast, axis_tdata, axis_tdest, axis_tuser,
    output axis_tid, axis_tstrb, axis_tkeep
  );

endinterface

// File: rtl/axis_client_arbiter_rr_arbiter.sv
// rtl/axis_client_arbiter_rr_arbiter.sv - combinational rotate-priority round-robin picker
module rr_arbiter
  import axis_client_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]                req,
  input  logic [clog2_min1(N)-1:0]    ptr,
  output logic [N-1:0]                grant_onehot,
  output logic [clog2_min1(N)-1:0]    grant_idx,
  output logic                        any
);

  localparam int PW = clog2_min1(N);

  int idx;

  // Scan from ptr upward with wrap; the first requester found wins.
  always_comb begin
    idx          = 0;
    any          = 1'b0;
    grant_idx    = '0;
    grant_onehot = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any       = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (any && (grant_idx == PW'(i))) grant_onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/axis_client_arbiter.sv
// rtl/axis_client_arbiter.sv - packet-granular round-robin mux of client streams onto one NoC port
module axis_client_arbiter
  import axis_client_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int DATAW       = AXIS_MAX_DATAW,
  parameter int DESTW       = AXIS_DESTW,
  parameter int USERW       = AXIS_USERW,
  parameter int IDW         = AXIS_IDW
) (
  input  logic                               clk,
  input  logic                               rst,
  axis_client_arbiter_if.slave               bus,
  output logic                               busy,
  output logic [clog2_min1(NUM_CLIENTS)-1:0] grant_id
);

  localparam int GW = clog2_min1(NUM_CLIENTS);

  arb_state_t              state;
  logic [GW-1:0]           rr_ptr;
  logic [GW-1:0]           lock_id;
  logic [NUM_CLIENTS-1:0]  pick_onehot;
  logic [GW-1:0]           pick;
  logic                    pick_any;
  logic [GW-1:0]           sel;
  logic                    sel_valid;
  logic                    sel_last;
  logic                    out_accept;
  logic                    xfer;
  logic [GW-1:0]           next_ptr;

  rr_arbiter #(.N(NUM_CLIENTS)) u_rr (
    .req          (bus.req_tvalid),
    .ptr          (rr_ptr),
    .grant_onehot (pick_onehot),
    .grant_idx    (pick),
    .any          (pick_any)
  );

  // No skid buffer: the output slot frees up in the same cycle axis_tready is seen.
  assign out_accept = ~bus.axis_tvalid | bus.axis_tready;
  assign sel        = (state == ST_LOCKED) ? lock_id : pick;
  assign sel_valid  = (state == ST_LOCKED) ? bus.req_tvalid[lock_id] : pick_any;
  assign sel_last   = bus.req_tlast[sel];
  assign xfer       = sel_valid & out_accept;
  assign next_ptr   = (sel == GW'(NUM_CLIENTS - 1)) ? '0 : sel + 1'b1;

  assign bus.axis_tstrb = '0;
  assign bus.axis_tkeep = '0;

  always_comb begin
    bus.req_tready = '0;
    if (state == ST_LOCKED) begin
      bus.req_tready[lock_id] = out_accept;
    end else begin
      bus.req_tready = pick_onehot & {NUM_CLIENTS{out_accept}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      lock_id         <= '0;
      busy            <= 1'b0;
      grant_id        <= '0;
      bus.axis_tvalid <= 1'b0;
      bus.axis_tlast  <= 1'b0;
      bus.axis_tdata  <= '0;
      bus.axis_tdest  <= '0;
      bus.axis_tuser  <= '0;
      bus.axis_tid    <= '0;
    end else begin
      if (xfer) begin
        bus.axis_tvalid <= 1'b1;
        bus.axis_tlast  <= sel_last;
        bus.axis_tdata  <= bus.req_tdata[int'(sel)*DATAW +: DATAW];
        bus.axis_tdest  <= bus.req_tdest[int'(sel)*DESTW +: DESTW];
        bus.axis_tuser  <= bus.req_tuser[int'(sel)*USERW +: USERW];
        bus.axis_tid    <= IDW'(sel);
      end else if (bus.axis_tready) begin
        bus.axis_tvalid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (xfer) begin
            if (sel_last) begin
              rr_ptr <= next_ptr;
            end else begin
              state    <= ST_LOCKED;
              lock_id  <= pick;
              busy     <= 1'b1;
              grant_id <= pick;
            end
          end
        end
        ST_LOCKED: begin
          // A stalled locked source keeps the grant; only its tlast beat releases it.
          if (xfer && sel_last) begin
            state    <= ST_IDLE;
            rr_ptr   <= next_ptr;
            busy     <= 1'b0;
            grant_id <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_client_arbiter.sv
// tb/tb_axis_client_arbiter.sv - directed self-checking bench for axis_client_arbiter
module tb_axis_client_arbiter;
  import axis_client_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int DSW = 4;
  localparam int UW  = 8;
  localparam int IW  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [1:0] grant_id;

  int checks = 0;
  int errors = 0;

  int beat [4];
  int pkt  [4];
  int cnt  [16];
  int es, eb, s;
  logic [3:0] rdy;
  logic [31:0] exp_data;

  axis_client_arbiter_if #(.NUM_CLIENTS(N), .DATAW(DW), .DESTW(DSW), .USERW(UW), .IDW(IW)) bus ();

  axis_client_arbiter #(.NUM_CLIENTS(N), .DATAW(DW), .DESTW(DSW), .USERW(UW), .IDW(IW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic l, input logic [31:0] d);
    bus.req_tvalid[i]          = v;
    bus.req_tlast[i]           = l;
    bus.req_tdata[i*DW +: DW]  = d;
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.axis_tready = 1'b1;
    clear_all();
    for (int i = 0; i < N; i++) begin
      bus.req_tdest[i*DSW +: DSW] = DSW'(i + 1);
      bus.req_tuser[i*UW +: UW]   = UW'(8'h80 + i);
    end

    // Reset values, then reset in the middle of a packet from source 1
    tick();
    tick();
    check("rst_tvalid", bus.axis_tvalid, 0);
    check("rst_tlast", bus.axis_tlast, 0);
    check("rst_tdata", bus.axis_tdata, 0);
    check("rst_tid", bus.axis_tid, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    rst = 1'b0;
    drive(1, 1'b1, 1'b0, 32'hA);
    #1;
    check("t1_ready_a", bus.req_tready, 4'b0010);
    tick();
    check("t1_data_a", bus.axis_tdata, 32'hA);
    check("t1_tid_a", bus.axis_tid, 1);
    check("t1_busy_a", busy, 1);
    check("t1_grant_a", grant_id, 1);
    drive(1, 1'b1, 1'b0, 32'hB);
    tick();
    check("t1_data_b", bus.axis_tdata, 32'hB);
    drive(1, 1'b1, 1'b0, 32'hC);
    rst = 1'b1;
    #1;
    check("t1_async_tvalid", bus.axis_tvalid, 0);
    check("t1_async_busy", busy, 0);
    check("t1_async_grant", grant_id, 0);
    tick();
    tick();
    drive(1, 1'b0, 1'b0, 32'h0);
    drive(2, 1'b1, 1'b1, 32'h2A);
    rst = 1'b0;
    #1;
    check("t1_ready_post", bus.req_tready, 4'b0100);
    tick();
    check("t1_post_data", bus.axis_tdata, 32'h2A);
    check("t1_post_tid", bus.axis_tid, 2);
    check("t1_post_last", bus.axis_tlast, 1);
    check("t1_post_busy", busy, 0);
    clear_all();
    tick();
    check("t1_idle_tvalid", bus.axis_tvalid, 0);

    // Round robin over four single-beat sources
    do_reset();
    for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b1, 32'h10 + i);
    #1;
    check("t2_ready0", bus.req_tready, 4'b0001);
    check("t2_no_early_tvalid", bus.axis_tvalid, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2_tvalid", bus.axis_tvalid, 1);
      check("t2_data", bus.axis_tdata, 32'h10 + (k % 4));
      check("t2_tid", bus.axis_tid, k % 4);
      check("t2_ready", bus.req_tready, 4'b0001 << ((k + 1) % 4));
    end
    clear_all();
    tick();
    check("t2_drain", bus.axis_tvalid, 0);

    // Packet lock: source 1 waits for the whole 3-beat packet of source 0
    do_reset();
    drive(0, 1'b1, 1'b0, 32'h1);
    drive(1, 1'b1, 1'b1, 32'h55);
    #1;
    check("t3_ready_b1", bus.req_tready, 4'b0001);
    tick();
    check("t3_data1", bus.axis_tdata, 32'h1);
    check("t3_busy", busy, 1);
    drive(0, 1'b1, 1'b0, 32'h2);
    #1;
    check("t3_ready_b2", bus.req_tready, 4'b0001);
    tick();
    check("t3_data2", bus.axis_tdata, 32'h2);
    drive(0, 1'b1, 1'b1, 32'h3);
    #1;
    check("t3_ready_b3", bus.req_tready, 4'b0001);
    tick();
    check("t3_data3", bus.axis_tdata, 32'h3);
    check("t3_last3", bus.axis_tlast, 1);
    check("t3_unlock", busy, 0);
    drive(0, 1'b0, 1'b0, 32'h0);
    #1;
    check("t3_ready_s1", bus.req_tready, 4'b0010);
    tick();
    check("t3_s1_tvalid", bus.axis_tvalid, 1);
    check("t3_s1_data", bus.axis_tdata, 32'h55);
    check("t3_s1_tid", bus.axis_tid, 1);
    clear_all();
    tick();

    // Backpressure: held beat stays stable, nothing accepted
    drive(2, 1'b1, 1'b1, 32'h77);
    drive(3, 1'b1, 1'b1, 32'h88);
    #1;
    check("t4_ready_first", bus.req_tready, 4'b0100);
    tick();
    check("t4_data_first", bus.axis_tdata, 32'h77);
    drive(2, 1'b0, 1'b0, 32'h0);
    bus.axis_tready = 1'b0;
    #1;
    check("t4_ready_blocked", bus.req_tready, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_hold_tvalid", bus.axis_tvalid, 1);
      check("t4_hold_data", bus.axis_tdata, 32'h77);
      check("t4_hold_last", bus.axis_tlast, 1);
      check("t4_hold_tid", bus.axis_tid, 2);
      check("t4_hold_ready", bus.req_tready, 4'b0000);
    end
    bus.axis_tready = 1'b1;
    #1;
    check("t4_release_ready", bus.req_tready, 4'b1000);
    tick();
    check("t4_next_data", bus.axis_tdata, 32'h88);
    check("t4_next_tid", bus.axis_tid, 3);
    clear_all();
    tick();

    // Locked source 2 stalls; source 3 must wait through the bubbles
    do_reset();
    drive(2, 1'b1, 1'b0, 32'h21);
    drive(3, 1'b1, 1'b1, 32'h31);
    #1;
    check("t5_ready_first", bus.req_tready, 4'b0100);
    tick();
    check("t5_data_first", bus.axis_tdata, 32'h21);
    drive(2, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_bubble", bus.axis_tvalid, 0);
      check("t5_busy", busy, 1);
      check("t5_grant", grant_id, 2);
      check("t5_ready", bus.req_tready, 4'b0100);
    end
    drive(2, 1'b1, 1'b1, 32'h22);
    tick();
    check("t5_data_last", bus.axis_tdata, 32'h22);
    check("t5_tid_last", bus.axis_tid, 2);
    check("t5_unlock", busy, 0);
    drive(2, 1'b0, 1'b0, 32'h0);
    tick();
    check("t5_s3_data", bus.axis_tdata, 32'h31);
    check("t5_s3_tid", bus.axis_tid, 3);
    clear_all();
    tick();

    // Fairness: sources 0 and 3 stream 2-beat packets back to back
    do_reset();
    for (int i = 0; i < 4; i++) begin
      beat[i] = 0;
      pkt[i]  = 0;
    end
    for (int i = 0; i < 16; i++) cnt[i] = 0;
    es = 0;
    eb = 0;
    for (int c = 0; c < 200; c++) begin
      for (int j = 0; j < 2; j++) begin
        s = j * 3;
        drive(s, 1'b1, beat[s] == 1, 32'((s << 12) | (pkt[s] << 4) | beat[s]));
      end
      #1;
      rdy = bus.req_tready;
      tick();
      exp_data = 32'((es << 12) | (pkt_expected(es, c) << 4) | eb);
      check("t6_tvalid", bus.axis_tvalid, 1);
      check("t6_data", bus.axis_tdata, exp_data);
      check("t6_tid", bus.axis_tid, es);
      check("t6_last", bus.axis_tlast, eb == 1);
      check("t6_dest", bus.axis_tdest, es + 1);
      check("t6_user", bus.axis_tuser, 8'h80 + es);
      if (bus.axis_tvalid && bus.axis_tlast) cnt[bus.axis_tid]++;
      if (eb == 1) begin
        es = (es == 0) ? 3 : 0;
        eb = 0;
      end else begin
        eb = 1;
      end
      for (int j = 0; j < 2; j++) begin
        s = j * 3;
        if (rdy[s]) begin
          if (beat[s] == 1) begin
            beat[s] = 0;
            pkt[s]  = pkt[s] + 1;
          end else begin
            beat[s] = 1;
          end
        end
      end
    end
    check("t6_cnt0", cnt[0], 50);
    check("t6_cnt3", cnt[3], 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Output beat c belongs to packet c/4 of whichever source alternation puts there.
  function automatic int pkt_expected(input int src, input int c);
    pkt_expected = (src == 0 || src == 3) ? (c / 4) : 0;
  endfunction

endmodule
